ru_data_buffer: RTL and testbench
=================================

// Module: ru_data_buffer
// PURPOSE
//   Multi-port staging buffer between the PE array and the recompute units (RUs) in the BISR
//   recompute-unit approach. Captures one PE result word per cycle, indexed by (row, col), and
//   tracks a valid bit per entry. Serves NUM_RU independent read ports with a req/valid handshake,
//   hit/miss status and optional consume-on-read. Reports occupancy to the BISR controller.
// PARAMETERS
//   ROWS          4   PE array rows (>=1, need not be a power of 2)
//   COLS          4   PE array columns (>=1, need not be a power of 2)
//   NUM_RU        4   number of RU read ports (>=1)
//   WORD_SIZE     16  data word width
//   CLEAR_ON_READ 1   1: a hit read clears the entry's valid bit; 0: reads are non-destructive
//   Derived: RW=$clog2(ROWS)>0?..:1, CW likewise, OW=$clog2(ROWS*COLS+1)
// PORTS
//   clk        in   1               clock, rising edge
//   rst_n      in   1               async active-low reset
//   clr        in   1               sync clear of all valid bits
//   wr_en      in   1               write strobe
//   wr_row     in   RW              write row index
//   wr_col     in   CW              write column index
//   wr_data    in   WORD_SIZE       write data
//   rd_req     in   NUM_RU          per-port read request
//   rd_row     in   NUM_RU*RW       packed read row, port i at [i*RW +: RW]
//   rd_col     in   NUM_RU*CW       packed read column, port i at [i*CW +: CW]
//   rd_valid   out  NUM_RU          response strobe, 1 cycle after rd_req
//   rd_miss    out  NUM_RU          qualifies rd_valid: entry was invalid or out of range
//   rd_data    out  NUM_RU*WORD_SIZE packed response data, 0 on miss
//   occupancy  out  OW              number of valid entries
//   wr_err     out  1               1-cycle pulse: write index out of range, write dropped
// BEHAVIOUR
//   - Reset: all valid bits 0; rd_valid, rd_miss, rd_data, occupancy, wr_err = 0. Data array not reset.
//   - Write: wr_en with in-range index -> data[r][c]<=wr_data, valid[r][c]<=1 at the next edge.
//     Rewriting a valid entry overwrites it, occupancy unchanged. Out of range (row>=ROWS or
//     col>=COLS) -> no state change, wr_err=1 next cycle.
//   - Read: rd_req[i] at edge N -> at N+1 rd_valid[i]=1 for exactly one cycle; hit: rd_miss[i]=0,
//     rd_data=stored word; miss/out of range: rd_miss[i]=1, rd_data=0. rd_data holds between responses.
//   - All ports read the same pre-edge state. Several ports hitting one entry all receive the data.
//     With CLEAR_ON_READ=1 that entry is cleared once and occupancy decrements once.
//   - Same-cycle write and consume of the same entry: the write wins. The entry ends valid with
//     wr_data, and the reader gets the old contents.
//   - clr: all valid <= 0 at the next edge and occupancy <= 0. clr overrides a write in the same
//     cycle, and that write is dropped with no wr_err. Reads issued in the clr cycle still return
//     the pre-clear state.
//   - occupancy: registered and consistent with the valid bits every cycle. Per-cycle delta =
//     +1 for a write to an invalid entry, -k for k distinct consumed entries.
//   - Reset assertion mid-operation: outputs clear immediately and any in-flight response is lost.
// CONFIGURATION
//   RU_BUF_BYPASS_EN defined: a read of the entry being written in the same cycle forwards
//   wr_data as a hit. With CLEAR_ON_READ=1 the forwarded write is consumed, so the entry ends
//   invalid and occupancy is unchanged.
//   Not defined: that read sees the pre-write state (miss if the entry was previously invalid).
// TESTING
//   1. Reset, wr (1,2)=16'hBEEF, then rd_req[0] (1,2) -> rd_valid[0]=1, rd_miss=0, rd_data=BEEF, occ 1->0.
//   2. CLEAR_ON_READ=0: write (0,0)=0x1234; all 4 ports read (0,0) same cycle -> four hits of 0x1234, occ=1.
//   3. Read never-written (3,3) -> rd_miss=1, rd_data=0. ROWS=3: write row 3 -> wr_err pulse, occ unchanged.
//   4. Same cycle: wr (2,1)=0xAAAA and rd (2,1). Without bypass: miss. With RU_BUF_BYPASS_EN: hit 0xAAAA, occ 0.
//   5. Fill all 16 entries -> occ=16. clr + wr_en same cycle -> occ=0, every subsequent read misses.
//   6. Drop rst_n while rd_req is in flight -> rd_valid=0 immediately, occ=0, no response after release.

Source files
------------

// File: rtl/ru_data_buffer_if.sv
// Write/read/status bundle between the PE-array side, the RU read ports and ru_data_buffer.
// Read ports are packed: port i uses rd_row[i*RW +: RW], rd_col[i*CW +: CW] and rd_data[i*WORD_SIZE +: WORD_SIZE].
interface ru_data_buffer_if #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int NUM_RU    = 4,
    parameter int WORD_SIZE = 16
);
    localparam int RW = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1;
    localparam int CW = ($clog2(COLS) > 0) ? $clog2(COLS) : 1;
    localparam int OW = $clog2(ROWS * COLS + 1);

    logic                        clr;
    logic                        wr_en;
    logic [RW-1:0]               wr_row;
    logic [CW-1:0]               wr_col;
    logic [WORD_SIZE-1:0]        wr_data;
    logic [NUM_RU-1:0]           rd_req;
    logic [NUM_RU*RW-1:0]        rd_row;
    logic [NUM_RU*CW-1:0]        rd_col;
    logic [NUM_RU-1:0]           rd_valid;
    logic [NUM_RU-1:0]           rd_miss;
    logic [NUM_RU*WORD_SIZE-1:0] rd_data;
    logic [OW-1:0]               occupancy;
    logic                        wr_err;

    modport master (
        output clr, wr_en, wr_row, wr_col, wr_data, rd_req, rd_row, rd_col,
        input  rd_valid, rd_miss, rd_data, occupancy, wr_err
    );

    modport slave (
        input  clr, wr_en, wr_row, wr_col, wr_data, rd_req, rd_row, rd_col,
        output rd_valid, rd_miss, rd_data, occupancy, wr_err
    );
endinterface

// File: rtl/ru_data_buffer.sv
// Multi-port (row,col)-indexed staging buffer between the PE array and the recompute units.
// Define RU_BUF_BYPASS_EN to forward a same-cycle write to readers of the entry being written.
module ru_data_buffer #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int NUM_RU        = 4,
    parameter int WORD_SIZE     = 16,
    parameter int CLEAR_ON_READ = 1
) (
    input logic              clk,
    input logic              rst_n,
    ru_data_buffer_if.slave  bus
);
    localparam int RW    = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1;
    localparam int CW    = ($clog2(COLS) > 0) ? $clog2(COLS) : 1;
    localparam int OW    = $clog2(ROWS * COLS + 1);
    localparam int NCELL = ROWS * COLS;
    localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam logic [RW:0] ROW_LIM = ROWS[RW:0];
    localparam logic [CW:0] COL_LIM = COLS[CW:0];

    function automatic logic in_range(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return ({1'b0, r} < ROW_LIM) && ({1'b0, c} < COL_LIM);
    endfunction

    function automatic logic [IW-1:0] flat_idx(input logic [RW-1:0] r, input logic [CW-1:0] c);
        logic [31:0] t;
        t = 32'(r) * 32'(COLS) + 32'(c);
        return t[IW-1:0];
    endfunction

    logic [WORD_SIZE-1:0] mem [NCELL];
    logic [NCELL-1:0]     valid_reg, valid_next;
    logic [OW-1:0]        occ_reg, occ_next;
    logic                 wr_err_reg;
    logic                 wr_ok, wr_fire;
    logic [IW-1:0]        wr_idx;
    logic [NCELL-1:0]     wr_mask, cons_mask;
    logic [NCELL-1:0]     port_cons [NUM_RU];

    // clr wins over a same-cycle write, which is silently dropped
    assign wr_ok   = in_range(bus.wr_row, bus.wr_col);
    assign wr_idx  = flat_idx(bus.wr_row, bus.wr_col);
    assign wr_fire = bus.wr_en && wr_ok && !bus.clr;

    always_comb begin
        wr_mask = '0;
        if (wr_fire) wr_mask[wr_idx] = 1'b1;
    end

    generate
        for (genvar gi = 0; gi < NUM_RU; gi++) begin : g_port
            logic [RW-1:0]        row;
            logic [CW-1:0]        col;
            logic [IW-1:0]        idx;
            logic                 ok, fwd, hit;
            logic [WORD_SIZE-1:0] word;
            logic                 rd_valid_reg, rd_miss_reg;
            logic [WORD_SIZE-1:0] rd_data_reg;

            assign row = bus.rd_row[gi*RW +: RW];
            assign col = bus.rd_col[gi*CW +: CW];
            assign ok  = in_range(row, col);
            assign idx = flat_idx(row, col);
`ifdef RU_BUF_BYPASS_EN
            assign fwd = ok && wr_fire && (idx == wr_idx);
`else
            assign fwd = 1'b0;
`endif
            assign hit  = bus.rd_req[gi] && ok && (valid_reg[idx] || fwd);
            assign word = fwd ? bus.wr_data : mem[idx];

            always_comb begin
                port_cons[gi] = '0;
                if (hit) port_cons[gi][idx] = 1'b1;
            end

            // rd_data only updates on a response so it holds between responses
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid_reg <= 1'b0;
                    rd_miss_reg  <= 1'b0;
                    rd_data_reg  <= '0;
                end else begin
                    rd_valid_reg <= bus.rd_req[gi];
                    rd_miss_reg  <= bus.rd_req[gi] && !hit;
                    if (bus.rd_req[gi]) rd_data_reg <= hit ? word : '0;
                end
            end

            assign bus.rd_valid[gi] = rd_valid_reg;
            assign bus.rd_miss[gi]  = rd_miss_reg;
            assign bus.rd_data[gi*WORD_SIZE +: WORD_SIZE] = rd_data_reg;
        end
    endgenerate

    // Several ports hitting one entry collapse into a single clear
    always_comb begin
        cons_mask = '0;
        for (int i = 0; i < NUM_RU; i++) cons_mask = cons_mask | port_cons[i];
        if (CLEAR_ON_READ == 0) cons_mask = '0;
    end

    always_comb begin
        if (bus.clr) begin
            valid_next = '0;
        end else begin
`ifdef RU_BUF_BYPASS_EN
            valid_next = (valid_reg | wr_mask) & ~cons_mask;
`else
            valid_next = (valid_reg & ~cons_mask) | wr_mask;
`endif
        end
        occ_next = '0;
        for (int i = 0; i < NCELL; i++) occ_next = occ_next + OW'(valid_next[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg  <= '0;
            occ_reg    <= '0;
            wr_err_reg <= 1'b0;
        end else begin
            valid_reg  <= valid_next;
            occ_reg    <= occ_next;
            wr_err_reg <= bus.wr_en && !wr_ok && !bus.clr;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_idx] <= bus.wr_data;
    end

    assign bus.occupancy = occ_reg;
    assign bus.wr_err    = wr_err_reg;
endmodule

// File: tb/tb_ru_data_buffer.sv
// Scoreboard bench for ru_data_buffer: three instances (4x4 consuming, 4x4 non-destructive, 3x4 consuming).
module tb_ru_data_buffer;
`ifdef RU_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic        miss;
        logic [15:0] data;
    } resp_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b1;
    int    tests = 0;
    int    failed = 0;
    resp_t exp_q [12][$];

    always #5 clk = ~clk;

    ru_data_buffer_if #(.ROWS(4), .COLS(4), .NUM_RU(4), .WORD_SIZE(16)) bus_a ();
    ru_data_buffer_if #(.ROWS(4), .COLS(4), .NUM_RU(4), .WORD_SIZE(16)) bus_b ();
    ru_data_buffer_if #(.ROWS(3), .COLS(4), .NUM_RU(4), .WORD_SIZE(16)) bus_c ();

    ru_data_buffer #(.ROWS(4), .COLS(4), .NUM_RU(4), .WORD_SIZE(16), .CLEAR_ON_READ(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    ru_data_buffer #(.ROWS(4), .COLS(4), .NUM_RU(4), .WORD_SIZE(16), .CLEAR_ON_READ(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    ru_data_buffer #(.ROWS(3), .COLS(4), .NUM_RU(4), .WORD_SIZE(16), .CLEAR_ON_READ(1))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    logic [3:0]  mv [3];
    logic [3:0]  mm [3];
    logic [63:0] md [3];
    assign mv[0] = bus_a.rd_valid; assign mm[0] = bus_a.rd_miss; assign md[0] = bus_a.rd_data;
    assign mv[1] = bus_b.rd_valid; assign mm[1] = bus_b.rd_miss; assign md[1] = bus_b.rd_data;
    assign mv[2] = bus_c.rd_valid; assign mm[2] = bus_c.rd_miss; assign md[2] = bus_c.rd_data;

    // Response monitor: every rd_valid pulse must match the oldest expectation of its port
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int k = 0; k < 3; k++) begin
                    for (int p = 0; p < 4; p++) begin
                        if (mv[k][p]) begin
                            tests++;
                            if (exp_q[k*4+p].size() == 0) begin
                                failed++;
                                $display("FAIL unexpected_resp inst=%0d port=%0d miss=%b data=%h required=no response",
                                         k, p, mm[k][p], md[k][p*16 +: 16]);
                            end else begin
                                e = exp_q[k*4+p].pop_front();
                                if (mm[k][p] !== e.miss || md[k][p*16 +: 16] !== e.data) begin
                                    failed++;
                                    $display("FAIL resp inst=%0d port=%0d got miss=%b data=%h required miss=%b data=%h",
                                             k, p, mm[k][p], md[k][p*16 +: 16], e.miss, e.data);
                                end else begin
                                    $display("[TB] resp inst=%0d port=%0d miss=%b data=%h ok",
                                             k, p, mm[k][p], md[k][p*16 +: 16]);
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int inst);
        case (inst)
            0: begin bus_a.clr = 0; bus_a.wr_en = 0; bus_a.rd_req = '0; end
            1: begin bus_b.clr = 0; bus_b.wr_en = 0; bus_b.rd_req = '0; end
            default: begin bus_c.clr = 0; bus_c.wr_en = 0; bus_c.rd_req = '0; end
        endcase
    endtask

    task automatic set_clr(input int inst, input logic v);
        case (inst)
            0: bus_a.clr = v;
            1: bus_b.clr = v;
            default: bus_c.clr = v;
        endcase
    endtask

    task automatic set_wr(input int inst, input int r, input int c, input logic [15:0] d);
        logic [1:0] rr, cc;
        rr = r[1:0];
        cc = c[1:0];
        case (inst)
            0: begin bus_a.wr_en = 1; bus_a.wr_row = rr; bus_a.wr_col = cc; bus_a.wr_data = d; end
            1: begin bus_b.wr_en = 1; bus_b.wr_row = rr; bus_b.wr_col = cc; bus_b.wr_data = d; end
            default: begin bus_c.wr_en = 1; bus_c.wr_row = rr; bus_c.wr_col = cc; bus_c.wr_data = d; end
        endcase
    endtask

    // Drive a read request and push the response the bench expects for it
    task automatic set_rd(input int inst, input int p, input int r, input int c,
                          input logic miss, input logic [15:0] d);
        logic [1:0] rr, cc;
        resp_t e;
        rr = r[1:0];
        cc = c[1:0];
        case (inst)
            0: begin bus_a.rd_req[p] = 1; bus_a.rd_row[p*2 +: 2] = rr; bus_a.rd_col[p*2 +: 2] = cc; end
            1: begin bus_b.rd_req[p] = 1; bus_b.rd_row[p*2 +: 2] = rr; bus_b.rd_col[p*2 +: 2] = cc; end
            default: begin bus_c.rd_req[p] = 1; bus_c.rd_row[p*2 +: 2] = rr; bus_c.rd_col[p*2 +: 2] = cc; end
        endcase
        e.miss = miss;
        e.data = miss ? 16'h0000 : d;
        exp_q[inst*4+p].push_back(e);
    endtask

    function automatic int occ(input int inst);
        case (inst)
            0: return int'(bus_a.occupancy);
            1: return int'(bus_b.occupancy);
            default: return int'(bus_c.occupancy);
        endcase
    endfunction

    function automatic logic wr_err_of(input int inst);
        case (inst)
            0: return bus_a.wr_err;
            1: return bus_b.wr_err;
            default: return bus_c.wr_err;
        endcase
    endfunction

    task automatic check_occ(input string name, input int inst, input int want);
        tests++;
        if (occ(inst) !== want) begin
            failed++;
            $display("FAIL %s occupancy=%0d required=%0d", name, occ(inst), want);
        end else $display("[TB] %s occupancy=%0d ok", name, want);
    endtask

    task automatic check_drained(input string name);
        int n;
        n = 0;
        for (int k = 0; k < 12; k++) n += exp_q[k].size();
        tests++;
        if (n != 0) begin
            failed++;
            $display("FAIL %s_drain pending responses=%0d required=0", name, n);
            for (int k = 0; k < 12; k++) exp_q[k].delete();
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) idle(k);
        bus_a.wr_row = 0; bus_a.wr_col = 0; bus_a.wr_data = 0; bus_a.rd_row = 0; bus_a.rd_col = 0;
        bus_b.wr_row = 0; bus_b.wr_col = 0; bus_b.wr_data = 0; bus_b.rd_row = 0; bus_b.rd_col = 0;
        bus_c.wr_row = 0; bus_c.wr_col = 0; bus_c.wr_data = 0; bus_c.rd_row = 0; bus_c.rd_col = 0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            tests++;
            if ({mv[k], mm[k], md[k]} !== '0 || occ(k) !== 0 || wr_err_of(k) !== 1'b0) begin
                failed++;
                $display("FAIL reset_outputs inst=%0d valid=%b miss=%b data=%h occ=%0d wr_err=%b required all 0",
                         k, mv[k], mm[k], md[k], occ(k), wr_err_of(k));
            end else $display("[TB] reset_outputs inst=%0d ok", k);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        set_wr(0, 1, 2, 16'hBEEF); tick(); idle(0);
        check_occ("t1_occ_after_write", 0, 1);
        set_rd(0, 0, 1, 2, 1'b0, 16'hBEEF); tick(); idle(0);
        check_occ("t1_occ_after_consume", 0, 0);
        tick();
        tests++;
        if (mv[0][0] !== 1'b0 || md[0][15:0] !== 16'hBEEF) begin
            failed++;
            $display("FAIL t1_hold valid=%b data=%h required valid=0 data=beef", mv[0][0], md[0][15:0]);
        end else $display("[TB] t1_hold ok");
        set_rd(0, 0, 1, 2, 1'b1, 16'h0); tick(); idle(0);
        tick();
        check_drained("t1");
    endtask

    task automatic test_multi_port();
        set_wr(1, 0, 0, 16'h1234); tick(); idle(1);
        for (int p = 0; p < 4; p++) set_rd(1, p, 0, 0, 1'b0, 16'h1234);
        tick(); idle(1);
        check_occ("t2_nc_occ", 1, 1);
        for (int p = 0; p < 4; p++) set_rd(1, p, 0, 0, 1'b0, 16'h1234);
        tick(); idle(1);
        check_occ("t2_nc_occ_again", 1, 1);
        set_wr(0, 2, 2, 16'h5A5A); tick(); idle(0);
        for (int p = 0; p < 4; p++) set_rd(0, p, 2, 2, 1'b0, 16'h5A5A);
        tick(); idle(0);
        check_occ("t2_cor_single_decrement", 0, 0);
        set_rd(0, 3, 2, 2, 1'b1, 16'h0); tick(); idle(0);
        tick();
        check_drained("t2");
    endtask

    task automatic test_miss_range();
        set_rd(0, 1, 3, 3, 1'b1, 16'h0); tick(); idle(0);
        set_wr(2, 3, 0, 16'h1357); tick(); idle(2);
        tests++;
        if (wr_err_of(2) !== 1'b1) begin
            failed++;
            $display("FAIL t3_wr_err_pulse wr_err=%b required=1", wr_err_of(2));
        end else $display("[TB] t3_wr_err_pulse ok");
        check_occ("t3_oor_occ", 2, 0);
        tick();
        tests++;
        if (wr_err_of(2) !== 1'b0) begin
            failed++;
            $display("FAIL t3_wr_err_one_cycle wr_err=%b required=0", wr_err_of(2));
        end else $display("[TB] t3_wr_err_one_cycle ok");
        set_wr(2, 2, 3, 16'h2468); tick(); idle(2);
        tests++;
        if (wr_err_of(2) !== 1'b0) begin
            failed++;
            $display("FAIL t3_inrange_no_err wr_err=%b required=0", wr_err_of(2));
        end
        check_occ("t3_inrange_occ", 2, 1);
        set_rd(2, 0, 3, 1, 1'b1, 16'h0);
        set_rd(2, 1, 2, 3, 1'b0, 16'h2468);
        tick(); idle(2);
        check_occ("t3_after_read_occ", 2, 0);
        tick();
        check_drained("t3");
    endtask

    task automatic test_same_cycle();
        set_wr(0, 2, 1, 16'hAAAA);
        set_rd(0, 1, 2, 1, !BYP, 16'hAAAA);
        tick(); idle(0);
        check_occ("t4_fresh_occ", 0, BYP ? 0 : 1);
        set_rd(0, 1, 2, 1, BYP, 16'hAAAA); tick(); idle(0);
        check_occ("t4_fresh_occ_final", 0, 0);
        set_wr(0, 0, 1, 16'h1111); tick(); idle(0);
        set_wr(0, 0, 1, 16'h2222);
        set_rd(0, 2, 0, 1, 1'b0, BYP ? 16'h2222 : 16'h1111);
        tick(); idle(0);
        check_occ("t4_write_wins_occ", 0, BYP ? 0 : 1);
        set_rd(0, 2, 0, 1, BYP, 16'h2222); tick(); idle(0);
        check_occ("t4_write_wins_final", 0, 0);
        tick();
        check_drained("t4");
    endtask

    task automatic test_fill_clear();
        for (int i = 0; i < 16; i++) begin
            set_wr(0, i / 4, i % 4, 16'hC000 + 16'(i));
            tick();
        end
        idle(0);
        check_occ("t5_full", 0, 16);
        set_wr(0, 1, 1, 16'hFFFF); tick(); idle(0);
        check_occ("t5_rewrite_full", 0, 16);
        set_clr(0, 1'b1);
        set_wr(0, 0, 0, 16'hDEAD);
        set_rd(0, 2, 3, 2, 1'b0, 16'hC00E);
        tick(); idle(0);
        check_occ("t5_after_clr", 0, 0);
        tests++;
        if (wr_err_of(0) !== 1'b0) begin
            failed++;
            $display("FAIL t5_clr_no_wr_err wr_err=%b required=0", wr_err_of(0));
        end
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < 4; p++) set_rd(0, p, r, p, 1'b1, 16'h0);
            tick(); idle(0);
        end
        tick();
        check_drained("t5");
    endtask

    task automatic test_back_to_back();
        logic        mvld [16];
        logic [15:0] mdat [16];
        logic        cons [16];
        int          cnt;
        for (int i = 0; i < 16; i++) begin mvld[i] = 1'b0; mdat[i] = '0; end
        for (int n = 0; n < 60; n++) begin
            logic        we, fwd, hit;
            int          w, idx;
            logic [15:0] d;
            we = 1'($urandom_range(0, 1));
            w  = $urandom_range(0, 5);
            d  = 16'($urandom);
            for (int i = 0; i < 16; i++) cons[i] = 1'b0;
            if (we) set_wr(0, w / 4, w % 4, d);
            for (int p = 0; p < 4; p++) begin
                if ($urandom_range(0, 2) != 0) begin
                    idx = $urandom_range(0, 5);
                    fwd = BYP && we && (idx == w);
                    hit = fwd || mvld[idx];
                    set_rd(0, p, idx / 4, idx % 4, !hit, fwd ? d : mdat[idx]);
                    if (hit) cons[idx] = 1'b1;
                end
            end
            if (BYP) begin
                if (we) begin mvld[w] = 1'b1; mdat[w] = d; end
                for (int i = 0; i < 16; i++) if (cons[i]) mvld[i] = 1'b0;
            end else begin
                for (int i = 0; i < 16; i++) if (cons[i]) mvld[i] = 1'b0;
                if (we) begin mvld[w] = 1'b1; mdat[w] = d; end
            end
            cnt = 0;
            for (int i = 0; i < 16; i++) cnt += int'(mvld[i]);
            tick(); idle(0);
            check_occ("b2b_occ", 0, cnt);
        end
        tick();
        check_drained("b2b");
    endtask

    task automatic test_reset_inflight();
        set_wr(0, 1, 1, 16'h7777); tick(); idle(0);
        set_rd(0, 0, 1, 1, 1'b0, 16'h7777);
        @(posedge clk); #1;
        idle(0);
        tests++;
        if (mv[0][0] !== 1'b1) begin
            failed++;
            $display("FAIL t6_inflight valid=%b required=1", mv[0][0]);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (mv[0] !== 4'b0 || mm[0] !== 4'b0 || md[0] !== 64'h0 || occ(0) !== 0) begin
            failed++;
            $display("FAIL t6_async_clear valid=%b miss=%b data=%h occ=%0d required all 0",
                     mv[0], mm[0], md[0], occ(0));
        end else $display("[TB] t6_async_clear ok");
        for (int k = 0; k < 12; k++) exp_q[k].delete();
        tick(); tick();
        rst_n = 1'b1;
        repeat (3) tick();
        tests++;
        if (mv[0] !== 4'b0 || occ(0) !== 0) begin
            failed++;
            $display("FAIL t6_after_release valid=%b occ=%0d required valid=0 occ=0", mv[0], occ(0));
        end else $display("[TB] t6_after_release ok");
        check_drained("t6");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_multi_port();
        test_miss_range();
        test_same_cycle();
        test_fill_clear();
        test_back_to_back();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
